// File: rtl/interrupt_acknowledge_vector_driver_if.sv
// Bus bundle between the interrupt-acknowledge responder and its surroundings:
// ICW configuration, INTA# pulse train, resolved request, and the driven byte/pulses.
interface interrupt_acknowledge_vector_driver_if;
    logic       interrupt_acknowledge_n;
    logic       u8086_or_mcs80_config;
    logic       call_address_interval_4_or_8_config;
    logic [2:0] interrupt_vector_address;
    logic [7:0] interrupt_vector_address_high;
    logic       write_initial_command_word_1;
    logic       acknowledge_interrupt_valid;
    logic [2:0] acknowledge_interrupt_level;
    logic [7:0] out_data;
    logic       out_data_enable;
    logic       latch_in_service;
    logic [2:0] captured_interrupt_level;
    logic       end_of_acknowledge;
    logic       acknowledge_abort;

    modport slave (
        input  interrupt_acknowledge_n,
        input  u8086_or_mcs80_config,
        input  call_address_interval_4_or_8_config,
        input  interrupt_vector_address,
        input  interrupt_vector_address_high,
        input  write_initial_command_word_1,
        input  acknowledge_interrupt_valid,
        input  acknowledge_interrupt_level,
        output out_data,
        output out_data_enable,
        output latch_in_service,
        output captured_interrupt_level,
        output end_of_acknowledge,
        output acknowledge_abort
    );

    modport master (
        output interrupt_acknowledge_n,
        output u8086_or_mcs80_config,
        output call_address_interval_4_or_8_config,
        output interrupt_vector_address,
        output interrupt_vector_address_high,
        output write_initial_command_word_1,
        output acknowledge_interrupt_valid,
        output acknowledge_interrupt_level,
        input  out_data,
        input  out_data_enable,
        input  latch_in_service,
        input  captured_interrupt_level,
        input  end_of_acknowledge,
        input  acknowledge_abort
    );
endinterface

// File: rtl/interrupt_acknowledge_vector_driver.sv
// Responder for the CPU interrupt-acknowledge cycle: follows the INTA# pulse train,
// drives CALL/vector bytes (MCS-80/85) or the vector byte (8086), and signals
// in-service latch, end of acknowledge and abort (timeout or ICW1 write).
module interrupt_acknowledge_vector_driver #(
    parameter logic [7:0]  CALL_OPCODE    = 8'hCD,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic clock,
    input logic reset_n,
    interrupt_acknowledge_vector_driver_if.slave ack_bus
);

    typedef enum logic [1:0] {IDLE, PULSE_LOW, PULSE_HIGH} state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [1:0] count_q, count_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic [2:0] level_q, level_d;
    logic       lis_q, lis_d;
    logic       eoa_q, eoa_d;
    logic       abort_q, abort_d;

    logic       fall, rise;
    logic [1:0] final_count;
    logic [2:0] new_level;

    assign fall        = inta_prev_q & ~ack_bus.interrupt_acknowledge_n;
    assign rise        = ~inta_prev_q & ack_bus.interrupt_acknowledge_n;
    assign final_count = ack_bus.u8086_or_mcs80_config ? 2'd2 : 2'd3;
    assign new_level   = ack_bus.acknowledge_interrupt_valid ?
                         ack_bus.acknowledge_interrupt_level : 3'd7;

    // {enable, byte} to present during INTA# pulse number pnum
    function automatic logic [8:0] vector_byte(input logic [1:0] pnum, input logic [2:0] lvl);
        logic [8:0] r;
        r = '0;
        if (ack_bus.u8086_or_mcs80_config) begin
            if (pnum == 2'd2)
                r = {1'b1, ack_bus.interrupt_vector_address_high[7:3], lvl};
        end else begin
            case (pnum)
                2'd1: r = {1'b1, CALL_OPCODE};
                2'd2: r = ack_bus.call_address_interval_4_or_8_config ?
                          {1'b1, ack_bus.interrupt_vector_address, lvl, 2'b00} :
                          {1'b1, ack_bus.interrupt_vector_address[2:1], lvl, 3'b000};
                2'd3: r = {1'b1, ack_bus.interrupt_vector_address_high};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // INTA# history for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) inta_prev_q <= 1'b1;
        else          inta_prev_q <= ack_bus.interrupt_acknowledge_n;
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            level_q <= '0;
            lis_q   <= 1'b0;
            eoa_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            en_q    <= en_d;
            level_q <= level_d;
            lis_q   <= lis_d;
            eoa_q   <= eoa_d;
            abort_q <= abort_d;
        end
    end

    // Next-state and output decode; ICW1 write overrides any INTA# edge
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        en_d    = en_q;
        level_d = level_q;
        lis_d   = 1'b0;
        eoa_d   = 1'b0;
        abort_d = 1'b0;

        if (ack_bus.write_initial_command_word_1) begin
            state_d = IDLE;
            count_d = '0;
            tmo_d   = '0;
            data_d  = '0;
            en_d    = 1'b0;
            abort_d = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        level_d          = new_level;
                        lis_d            = 1'b1;
                        count_d          = 2'd1;
                        tmo_d            = '0;
                        {en_d, data_d}   = vector_byte(2'd1, new_level);
                        state_d          = PULSE_LOW;
                    end
                end
                PULSE_LOW: begin
                    if (rise) begin
                        en_d   = 1'b0;
                        data_d = '0;
                        tmo_d  = '0;
                        if (count_q == final_count) begin
                            eoa_d   = 1'b1;
                            count_d = '0;
                            state_d = IDLE;
                        end else begin
                            state_d = PULSE_HIGH;
                        end
                    end
                end
                PULSE_HIGH: begin
                    if (fall) begin
                        count_d        = count_q + 2'd1;
                        tmo_d          = '0;
                        {en_d, data_d} = vector_byte(count_q + 2'd1, level_q);
                        state_d        = PULSE_LOW;
                    end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        abort_d = 1'b1;
                        tmo_d   = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ack_bus.out_data                 = data_q;
    assign ack_bus.out_data_enable          = en_q;
    assign ack_bus.latch_in_service         = lis_q;
    assign ack_bus.captured_interrupt_level = level_q;
    assign ack_bus.end_of_acknowledge       = eoa_q;
    assign ack_bus.acknowledge_abort        = abort_q;

endmodule

// File: tb/tb_interrupt_acknowledge_vector_driver.sv
// Directed bench for interrupt_acknowledge_vector_driver: table of full INTA#
// sequences plus hand-written timeout, ICW1 abort and async reset sequences.
module tb_interrupt_acknowledge_vector_driver;

    localparam int unsigned TMO = 255;

    logic clock;
    logic reset_n;

    interrupt_acknowledge_vector_driver_if ifc();

    interrupt_acknowledge_vector_driver #(
        .CALL_OPCODE   (8'hCD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ack_bus(ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             mode;     // 1 = 8086
        logic             adi;
        logic [2:0]       a75;
        logic [7:0]       high;
        logic             valid;
        logic [2:0]       lvl;
        int               np;
        logic [2:0][8:0]  exp;      // {enable, byte} per pulse
        logic [2:0]       exp_lvl;
    } vec_t;

    vec_t vecs[5];

    int total = 0;
    int passed = 0;
    int lis_cnt, eoa_cnt, abort_cnt;
    int multi_cnt = 0;
    int overlap_cnt = 0;
    logic lis_prev = 1'b0, eoa_prev = 1'b0, abort_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (ifc.latch_in_service)   lis_cnt++;
        if (ifc.end_of_acknowledge) eoa_cnt++;
        if (ifc.acknowledge_abort)  abort_cnt++;
        if ((ifc.latch_in_service && lis_prev) || (ifc.end_of_acknowledge && eoa_prev) ||
            (ifc.acknowledge_abort && abort_prev))
            multi_cnt++;
        if (ifc.latch_in_service && ifc.end_of_acknowledge) overlap_cnt++;
        lis_prev   = ifc.latch_in_service;
        eoa_prev   = ifc.end_of_acknowledge;
        abort_prev = ifc.acknowledge_abort;
    endtask

    task automatic clear_counts();
        lis_cnt = 0;
        eoa_cnt = 0;
        abort_cnt = 0;
    endtask

    task automatic set_cfg(input vec_t v);
        ifc.u8086_or_mcs80_config               = v.mode;
        ifc.call_address_interval_4_or_8_config = v.adi;
        ifc.interrupt_vector_address            = v.a75;
        ifc.interrupt_vector_address_high       = v.high;
        ifc.acknowledge_interrupt_valid         = v.valid;
        ifc.acknowledge_interrupt_level         = v.lvl;
    endtask

    // One INTA# pulse: 4 clocks low, 3 clocks high
    task automatic pulse(input string tag, input logic [8:0] exp);
        ifc.interrupt_acknowledge_n = 1'b0;
        tick();
        check({tag, "_byte"}, {23'd0, ifc.out_data_enable, ifc.out_data}, {23'd0, exp});
        tick(); tick(); tick();
        ifc.interrupt_acknowledge_n = 1'b1;
        tick();
        check({tag, "_released"}, {23'd0, ifc.out_data_enable, ifc.out_data}, 32'd0);
        tick(); tick();
    endtask

    task automatic run_vec(input int vi);
        set_cfg(vecs[vi]);
        clear_counts();
        for (int p = 0; p < vecs[vi].np; p++)
            pulse($sformatf("v%0d_p%0d", vi, p + 1), vecs[vi].exp[p]);
        check($sformatf("v%0d_level", vi), {29'd0, ifc.captured_interrupt_level}, {29'd0, vecs[vi].exp_lvl});
        check($sformatf("v%0d_lis_count", vi), lis_cnt, 1);
        check($sformatf("v%0d_end_count", vi), eoa_cnt, 1);
        check($sformatf("v%0d_abort_count", vi), abort_cnt, 0);
    endtask

    initial begin
        int n;
        logic seen;

        // 8086, ICW2 40, level 5 -> pulse1 silent, pulse2 45
        vecs[0] = '{mode:1'b1, adi:1'b0, a75:3'b000, high:8'h40, valid:1'b1, lvl:3'd5, np:2,
                    exp:{9'h000, 9'h145, 9'h000}, exp_lvl:3'd5};
        // MCS-80 ADI=1, A=101, ICW2 12, level 3 -> CD AC 12
        vecs[1] = '{mode:1'b0, adi:1'b1, a75:3'b101, high:8'h12, valid:1'b1, lvl:3'd3, np:3,
                    exp:{9'h112, 9'h1AC, 9'h1CD}, exp_lvl:3'd3};
        // MCS-80 ADI=0, A=110, no valid request -> spurious 7, low byte F8
        vecs[2] = '{mode:1'b0, adi:1'b0, a75:3'b110, high:8'h34, valid:1'b0, lvl:3'd2, np:3,
                    exp:{9'h134, 9'h1F8, 9'h1CD}, exp_lvl:3'd7};
        // 8086 spurious: ICW2 A5 -> {10100,111} = A7
        vecs[3] = '{mode:1'b1, adi:1'b1, a75:3'b111, high:8'hA5, valid:1'b0, lvl:3'd2, np:2,
                    exp:{9'h000, 9'h1A7, 9'h000}, exp_lvl:3'd7};
        // MCS-80 ADI=0, A7A6=01, level 4 -> {01,100,000} = 60
        vecs[4] = '{mode:1'b0, adi:1'b0, a75:3'b011, high:8'hFE, valid:1'b1, lvl:3'd4, np:3,
                    exp:{9'h1FE, 9'h160, 9'h1CD}, exp_lvl:3'd4};

        ifc.interrupt_acknowledge_n      = 1'b1;
        ifc.write_initial_command_word_1 = 1'b0;
        set_cfg(vecs[0]);
        clear_counts();
        reset_n = 1'b0;
        tick(); tick();
        check("reset_bus", {23'd0, ifc.out_data_enable, ifc.out_data}, 32'd0);
        check("reset_level", {29'd0, ifc.captured_interrupt_level}, 32'd0);
        check("reset_pulses", {29'd0, ifc.latch_in_service, ifc.end_of_acknowledge,
                               ifc.acknowledge_abort}, 32'd0);
        reset_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 5; i++) run_vec(i);

        // Timeout after one 8086 pulse, then a normal pair
        set_cfg(vecs[0]);
        clear_counts();
        ifc.interrupt_acknowledge_n = 1'b0;
        tick();
        check("tmo_p1_byte", {23'd0, ifc.out_data_enable, ifc.out_data}, 32'd0);
        tick(); tick(); tick();
        ifc.interrupt_acknowledge_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (ifc.acknowledge_abort) seen = 1'b1;
        end
        check("tmo_abort_seen", {31'd0, seen}, 32'd1);
        check("tmo_cycles", n, TMO + 1);
        tick(); tick();
        check("tmo_abort_count", abort_cnt, 1);
        check("tmo_no_end", eoa_cnt, 0);
        run_vec(0);

        // ICW1 write during MCS-80 pulse 2
        set_cfg(vecs[1]);
        clear_counts();
        pulse("icw_p1", 9'h1CD);
        ifc.interrupt_acknowledge_n = 1'b0;
        tick();
        check("icw_p2_byte", {23'd0, ifc.out_data_enable, ifc.out_data}, {23'd0, 9'h1AC});
        ifc.write_initial_command_word_1 = 1'b1;
        tick();
        ifc.write_initial_command_word_1 = 1'b0;
        check("icw_bus_off", {23'd0, ifc.out_data_enable, ifc.out_data}, 32'd0);
        check("icw_abort_pulse", {31'd0, ifc.acknowledge_abort}, 32'd1);
        tick();
        ifc.interrupt_acknowledge_n = 1'b1;
        tick(); tick(); tick();
        check("icw_abort_count", abort_cnt, 1);
        check("icw_no_end", eoa_cnt, 0);
        run_vec(1);

        // Asynchronous reset during pulse 2
        set_cfg(vecs[1]);
        clear_counts();
        pulse("rst_p1", 9'h1CD);
        ifc.interrupt_acknowledge_n = 1'b0;
        tick();
        check("rst_p2_byte", {23'd0, ifc.out_data_enable, ifc.out_data}, {23'd0, 9'h1AC});
        #3 reset_n = 1'b0;
        #1;
        check("rst_async_bus", {23'd0, ifc.out_data_enable, ifc.out_data}, 32'd0);
        check("rst_async_level", {29'd0, ifc.captured_interrupt_level}, 32'd0);
        ifc.interrupt_acknowledge_n = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        run_vec(1);

        check("pulse_width", multi_cnt, 0);
        check("lis_end_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
